axis_testpattern_checker: RTL and testbench
===========================================

AXIS_TESTPATTERN_CHECKER -- requirements
Module: axis_testpattern_checker

Interface
REQ-001 SHALL have parameter S00_AXIS_TDATA_WIDTH, default 32, stream data width.
REQ-002 SHALL have parameter COUNTER_START, default 0, first value of the pattern.
REQ-003 SHALL have parameter COUNTER_END, default 255, last value before wrap.
REQ-004 SHALL have parameter COUNTER_INCR, default 1, step between consecutive values.
REQ-005 SHALL have parameter LOCK_COUNT, default 4, consecutive matches needed to lock (range 1..15).
REQ-006 SHALL have parameter UNLOCK_COUNT, default 3, consecutive mismatches that drop lock (range 1..15).
REQ-007 SHALL have port s_axis_aclk, input, 1, sole clock; all logic is on its rising edge.
REQ-008 SHALL have port s_axis_aresetn, input, 1, reset, asynchronous and active-low.
REQ-009 SHALL have port enable, input, 1, allows beats to be accepted.
REQ-010 SHALL have port clear, input, 1, synchronous clear of statistics and lock.
REQ-011 SHALL have port s_axis_tdata, input, S00_AXIS_TDATA_WIDTH, received pattern word.
REQ-012 SHALL have port s_axis_tvalid, input, 1, upstream valid.
REQ-013 SHALL have port s_axis_tready, output, 1, checker ready.
REQ-014 SHALL have port locked, output, 1, high while in state LOCKED.
REQ-015 SHALL have port error_pulse, output, 1, one-cycle strobe per counted mismatch.
REQ-016 SHALL have port word_count, output, 32, accepted beats while LOCKED.
REQ-017 SHALL have port error_count, output, 32, mismatches counted while LOCKED.
REQ-018 SHALL have port lock_loss_count, output, 16, LOCKED->HUNT transitions.

Function
REQ-019 s_axis_tready SHALL be enable registered by one cycle.
REQ-020 A beat SHALL be accepted only in a cycle where s_axis_tvalid and s_axis_tready are both 1.
REQ-021 Successor next(x) SHALL be x-(COUNTER_END-COUNTER_START) when x>=COUNTER_END, else x+COUNTER_INCR, computed at full tdata width with the expected value zero-extended.
REQ-022 A register expected, of tdata width, SHALL be set to next(s_axis_tdata) on every accepted beat, whether or not the beat matched, giving resync after an error.
REQ-023 The FSM SHALL have states HUNT, LOCKED and a 4-bit run counter run_cnt.
REQ-024 In HUNT, the first accepted beat after entry SHALL only seed expected, with run_cnt cleared.
REQ-025 In HUNT, each later matching beat SHALL increment run_cnt; a mismatch SHALL clear run_cnt.
REQ-026 HUNT SHALL go to LOCKED on the beat that brings run_cnt to LOCK_COUNT, and run_cnt SHALL be cleared.
REQ-027 In LOCKED, every accepted beat SHALL increment word_count.
REQ-028 In LOCKED, a mismatch SHALL increment error_count, assert error_pulse in the following cycle, and increment run_cnt.
REQ-029 In LOCKED, a matching beat SHALL clear run_cnt.
REQ-030 LOCKED SHALL go to HUNT on the mismatch that brings run_cnt to UNLOCK_COUNT; that mismatch is still counted, lock_loss_count increments, and run_cnt clears.
REQ-031 HUNT entered from LOCKED SHALL treat the next beat as a seed beat per REQ-024.
REQ-032 All counters SHALL saturate at all-ones and never wrap.
REQ-033 clear SHALL zero all counters, deassert locked and error_pulse, and enter HUNT awaiting a seed beat.
REQ-034 clear SHALL take priority over a simultaneously accepted beat; that beat is ignored.
REQ-035 Deasserting enable SHALL freeze all state; state resumes unchanged when enable returns, with no implicit resync.
REQ-036 locked SHALL be driven directly by the state register, so it asserts the cycle after the locking beat.
REQ-037 word_count and error_count SHALL update the cycle after the beat.

Reset
REQ-038 On s_axis_aresetn=0, all of the following SHALL take effect asynchronously: state=HUNT awaiting seed, run_cnt=0, expected=0, s_axis_tready=0, locked=0, error_pulse=0, all counters 0.
REQ-039 Reset mid-stream SHALL discard all history; after release, the first accepted beat is a seed beat.

Structure
REQ-040 Shared package axis_testpattern_pkg SHALL hold the FSM state encoding and the next-value function, so the generator and checker use identical wrap arithmetic.
REQ-041 One sub-module, axis_tp_sat_counter (parameterised width, synchronous inc/clr, saturating), SHALL be instantiated for each of the three statistics counters.

Verification
REQ-042 Reset release, enable=1, values 0,1,2,3,4,5 -> locked rises the cycle after beat 4; word_count=1 after beat 5; error_count=0.
REQ-043 While locked, feed ...,254,255,0,1 -> no error_pulse and error_count stays 0 (wrap accepted).
REQ-044 While locked, feed 10,11,99,100,101 -> exactly one error_pulse, error_count=1, locked stays 1 (resync after 99).
REQ-045 While locked, feed 3 mismatches in a row (7,20,40,60) -> error_count=3, locked drops after 60, lock_loss_count=1; next 4 matching beats after a seed beat relock.
REQ-046 Assert clear on the same cycle as an accepted mismatching beat -> counters=0, locked=0, no error_pulse.
REQ-047 Toggle enable low for 10 cycles mid-stream with tvalid=1 -> tready low 1 cycle later, no counter change, checking continues correctly after re-enable; async reset mid-beat -> all outputs 0 immediately.

Source files
------------

// File: rtl/axis_testpattern_pkg.sv
// ---------------------------------------------------------------------------
// axis_testpattern_pkg
// Shared definitions for the AXI-Stream counting test pattern. Both the
// generator and the checker take their wrap arithmetic from tp_next() so the
// two ends can never disagree on what "the next value" is.
//   tp_state_e : checker FSM state encoding (HUNT / LOCKED)
//   TP_MAX_W   : widest tdata the next-value helper supports
//   tp_next()  : successor of a pattern value
// ---------------------------------------------------------------------------
package axis_testpattern_pkg;

  localparam int TP_MAX_W = 64;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } tp_state_e;

  // Successor of x. At or past the end value the pattern steps back by the
  // span (end - start), so an off-grid value still lands somewhere sensible.
  // Callers zero-extend tdata to TP_MAX_W and truncate the result back.
  function automatic logic [TP_MAX_W-1:0] tp_next(
    input logic [TP_MAX_W-1:0] x,
    input logic [TP_MAX_W-1:0] c_start,
    input logic [TP_MAX_W-1:0] c_end,
    input logic [TP_MAX_W-1:0] c_incr
  );
    if (x >= c_end) begin
      return x - (c_end - c_start);
    end
    return x + c_incr;
  endfunction

endpackage

// File: rtl/axis_testpattern_checker_if.sv
// ---------------------------------------------------------------------------
// axis_testpattern_checker_if
// AXI-Stream data channel carrying the test pattern.
//   tdata  : pattern word (master -> slave)
//   tvalid : word on tdata is valid (master -> slave)
//   tready : slave can take a word (slave -> master)
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both 1. Once tvalid is raised the master holds tdata stable until the
// transfer; tready may change freely and does not depend on tvalid.
// ---------------------------------------------------------------------------
interface axis_testpattern_checker_if #(
  parameter int TDATA_WIDTH = 32
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_tp_sat_counter.sv
// ---------------------------------------------------------------------------
// axis_tp_sat_counter
// Statistics counter that sticks at all-ones instead of wrapping.
//   clk_i   : clock (rising edge)
//   rst_ni  : asynchronous active-low reset, zeroes the count
//   clr_i   : synchronous clear, wins over inc_i
//   inc_i   : add one this cycle (ignored once saturated)
//   count_o : current count
// ---------------------------------------------------------------------------
module axis_tp_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/axis_testpattern_checker.sv
// ---------------------------------------------------------------------------
// axis_testpattern_checker
// Receives a counting test pattern on an AXI-Stream slave port, locks onto it
// after LOCK_COUNT consecutive correct words and then counts words, errors and
// lock losses.
//   s_axis_aclk     : sole clock, rising edge
//   s_axis_aresetn  : asynchronous active-low reset
//   enable          : lets beats be accepted (tready follows one cycle later)
//   clear           : synchronous clear of statistics and lock
//   s_axis          : pattern stream (slave modport)
//   locked          : high while the FSM is LOCKED
//   error_pulse     : one-cycle strobe the cycle after a counted mismatch
//   word_count      : beats accepted while LOCKED
//   error_count     : mismatches counted while LOCKED
//   lock_loss_count : LOCKED -> HUNT transitions
//   dbg_state_o     : FSM state, for observation
// Supports S00_AXIS_TDATA_WIDTH up to TP_MAX_W.
// ---------------------------------------------------------------------------
module axis_testpattern_checker
  import axis_testpattern_pkg::*;
#(
  parameter int S00_AXIS_TDATA_WIDTH = 32,
  parameter int COUNTER_START        = 0,
  parameter int COUNTER_END          = 255,
  parameter int COUNTER_INCR         = 1,
  parameter int LOCK_COUNT           = 4,
  parameter int UNLOCK_COUNT         = 3
) (
  input  logic                        s_axis_aclk,
  input  logic                        s_axis_aresetn,
  input  logic                        enable,
  input  logic                        clear,
  axis_testpattern_checker_if.slave   s_axis,
  output logic                        locked,
  output logic                        error_pulse,
  output logic [31:0]                 word_count,
  output logic [31:0]                 error_count,
  output logic [15:0]                 lock_loss_count,
  output tp_state_e                   dbg_state_o
);

  localparam int W = S00_AXIS_TDATA_WIDTH;

  tp_state_e   state_q, state_d;
  logic        seed_q, seed_d;      // next accepted beat only seeds expected
  logic [3:0]  run_q, run_d;        // consecutive match (HUNT) / mismatch (LOCKED) run
  logic [W-1:0] expected_q, expected_d;
  logic        tready_q;
  logic        pulse_q, pulse_d;

  logic        accept;
  logic        match;
  logic [3:0]  run_inc;
  logic        word_inc, err_inc, loss_inc, stats_clr;

  assign accept  = s_axis.tvalid & tready_q;
  assign match   = (s_axis.tdata == expected_q);
  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    run_d      = run_q;
    expected_d = expected_q;
    pulse_d    = 1'b0;
    word_inc   = 1'b0;
    err_inc    = 1'b0;
    loss_inc   = 1'b0;
    stats_clr  = 1'b0;

    if (clear) begin
      // Clear wins over a beat accepted in the same cycle; that beat is dropped.
      stats_clr = 1'b1;
      state_d   = ST_HUNT;
      seed_d    = 1'b1;
      run_d     = 4'd0;
    end else if (accept) begin
      // Always re-predict from the received word so one bad word costs one
      // error, not an error on every word after it.
      expected_d = W'(tp_next(TP_MAX_W'(s_axis.tdata),
                              TP_MAX_W'(COUNTER_START),
                              TP_MAX_W'(COUNTER_END),
                              TP_MAX_W'(COUNTER_INCR)));
      case (state_q)
        ST_HUNT: begin
          if (seed_q) begin
            seed_d = 1'b0;
            run_d  = 4'd0;
          end else if (match) begin
            if (run_inc == 4'(LOCK_COUNT)) begin
              state_d = ST_LOCKED;
              run_d   = 4'd0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          word_inc = 1'b1;
          if (match) begin
            run_d = 4'd0;
          end else begin
            err_inc = 1'b1;
            pulse_d = 1'b1;
            if (run_inc == 4'(UNLOCK_COUNT)) begin
              state_d  = ST_HUNT;
              seed_d   = 1'b1;
              run_d    = 4'd0;
              loss_inc = 1'b1;
            end else begin
              run_d = run_inc;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          seed_d  = 1'b1;
          run_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q    <= ST_HUNT;
      seed_q     <= 1'b1;
      run_q      <= 4'd0;
      expected_q <= '0;
      tready_q   <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      run_q      <= run_d;
      expected_q <= expected_d;
      tready_q   <= enable;
      pulse_q    <= pulse_d;
    end
  end

  axis_tp_sat_counter #(.WIDTH(32)) u_word_cnt (
    .clk_i   (s_axis_aclk),
    .rst_ni  (s_axis_aresetn),
    .clr_i   (stats_clr),
    .inc_i   (word_inc),
    .count_o (word_count)
  );

  axis_tp_sat_counter #(.WIDTH(32)) u_err_cnt (
    .clk_i   (s_axis_aclk),
    .rst_ni  (s_axis_aresetn),
    .clr_i   (stats_clr),
    .inc_i   (err_inc),
    .count_o (error_count)
  );

  axis_tp_sat_counter #(.WIDTH(16)) u_loss_cnt (
    .clk_i   (s_axis_aclk),
    .rst_ni  (s_axis_aresetn),
    .clr_i   (stats_clr),
    .inc_i   (loss_inc),
    .count_o (lock_loss_count)
  );

  assign s_axis.tready = tready_q;
  assign locked        = (state_q == ST_LOCKED);
  assign error_pulse   = pulse_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axis_testpattern_checker.sv
module tb_axis_testpattern_checker;
  import axis_testpattern_pkg::*;

  localparam int W  = 32;
  localparam int CS = 0;
  localparam int CE = 255;
  localparam int CI = 1;
  localparam int LC = 4;
  localparam int UC = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic        clear  = 1'b0;
  logic        locked, error_pulse;
  logic [31:0] word_count, error_count;
  logic [15:0] lock_loss_count;
  tp_state_e   dbg_state;

  axis_testpattern_checker_if #(.TDATA_WIDTH(W)) s_axis ();

  always #5 clk = ~clk;

  axis_testpattern_checker #(
    .S00_AXIS_TDATA_WIDTH (W),
    .COUNTER_START        (CS),
    .COUNTER_END          (CE),
    .COUNTER_INCR         (CI),
    .LOCK_COUNT           (LC),
    .UNLOCK_COUNT         (UC)
  ) dut (
    .s_axis_aclk     (clk),
    .s_axis_aresetn  (rst_n),
    .enable          (enable),
    .clear           (clear),
    .s_axis          (s_axis),
    .locked          (locked),
    .error_pulse     (error_pulse),
    .word_count      (word_count),
    .error_count     (error_count),
    .lock_loss_count (lock_loss_count),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];   // predicted error_count at each error_pulse

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the checker as described: lock after LC clean words following a
  // seed word, unlock after UC errors in a row, statistics only while locked.
  bit           m_tready, m_locked, m_seed, m_pulse;
  int           m_streak;
  logic [W-1:0] m_exp;
  longint unsigned m_word, m_errc, m_loss;

  function automatic logic [W-1:0] m_next(input logic [W-1:0] x);
    longint unsigned v;
    v = longint'(x);
    if (v >= CE) v = v - (CE - CS);
    else         v = v + CI;
    return W'(v);
  endfunction

  task automatic model_reset();
    m_tready = 0; m_locked = 0; m_seed = 1; m_pulse = 0;
    m_streak = 0; m_exp = '0; m_word = 0; m_errc = 0; m_loss = 0;
    exp_q.delete();
  endtask

  task automatic check_all();
    check("tready", s_axis.tready, m_tready);
    check("locked", locked, m_locked);
    check("error_pulse", error_pulse, m_pulse);
    check("word_count", word_count, m_word);
    check("error_count", error_count, m_errc);
    check("lock_loss_count", lock_loss_count, m_loss);
    if (error_pulse) begin
      if (exp_q.size() == 0) check("pulse_unexpected", 1, 0);
      else                   check("pulse_error_count", error_count, exp_q.pop_front());
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input logic [W-1:0] d, input bit en, input bit clr);
    s_axis.tvalid = v;
    s_axis.tdata  = d;
    enable        = en;
    clear         = clr;
  endtask

  // One clock: advance the model with the inputs set at the previous
  // negedge, then compare everything on the following negedge.
  task automatic tick();
    bit acc, match, pulse;
    acc = s_axis.tvalid && m_tready;
    @(posedge clk);
    pulse = 0;
    if (clear) begin
      m_word = 0; m_errc = 0; m_loss = 0;
      m_locked = 0; m_seed = 1; m_streak = 0;
    end else if (acc) begin
      match = (s_axis.tdata == m_exp);
      m_exp = m_next(s_axis.tdata);
      if (!m_locked) begin
        if (m_seed) begin
          m_seed = 0; m_streak = 0;
        end else if (match) begin
          m_streak++;
          if (m_streak == LC) begin m_locked = 1; m_streak = 0; end
        end else begin
          m_streak = 0;
        end
      end else begin
        if (m_word < 64'hFFFF_FFFF) m_word++;
        if (match) begin
          m_streak = 0;
        end else begin
          if (m_errc < 64'hFFFF_FFFF) m_errc++;
          pulse = 1;
          m_streak++;
          if (m_streak == UC) begin
            m_locked = 0; m_seed = 1; m_streak = 0;
            if (m_loss < 64'hFFFF) m_loss++;
          end
        end
      end
    end
    m_tready = enable;
    m_pulse  = pulse;
    if (pulse) exp_q.push_back(W'(m_errc));
    @(negedge clk);
    check_all();
  endtask

  task automatic beat(input logic [W-1:0] d);
    drive(1, d, 1, 0);
    tick();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [W-1:0] data;
    bit           e_locked;
    bit           e_pulse;
    int           e_word;
    int           e_err;
  } vec_t;

  vec_t vecs[10];
  int   pulses;
  int   err_rate;

  initial begin
    vecs[0] = '{0,   0, 0, 0, 0};
    vecs[1] = '{1,   0, 0, 0, 0};
    vecs[2] = '{2,   0, 0, 0, 0};
    vecs[3] = '{3,   0, 0, 0, 0};
    vecs[4] = '{4,   1, 0, 0, 0};
    vecs[5] = '{5,   1, 0, 1, 0};
    vecs[6] = '{6,   1, 0, 2, 0};
    vecs[7] = '{99,  1, 1, 3, 1};
    vecs[8] = '{100, 1, 0, 4, 1};
    vecs[9] = '{101, 1, 0, 5, 1};

    // Reset state
    drive(0, 0, 0, 0);
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_all();
    check("reset_state", dbg_state, ST_HUNT);
    rst_n = 1;

    drive(0, 0, 1, 0);
    tick();
    check("tready_after_enable", s_axis.tready, 1);

    // Lock-up and first error, table driven
    foreach (vecs[i]) begin
      beat(vecs[i].data);
      check($sformatf("vec%0d_locked", i), locked, vecs[i].e_locked);
      check($sformatf("vec%0d_pulse", i), error_pulse, vecs[i].e_pulse);
      check($sformatf("vec%0d_word", i), word_count, vecs[i].e_word);
      check($sformatf("vec%0d_err", i), error_count, vecs[i].e_err);
    end

    // Wrap 255 -> 0 while locked must not be an error
    pulses = 0;
    for (int v = 102; v <= 257; v++) begin
      beat(W'(v % 256));
      pulses += int'(error_pulse);
    end
    check("wrap_pulses", pulses, 0);
    check("wrap_err", error_count, 1);
    check("wrap_locked", locked, 1);

    // Three errors in a row drop lock, then relock after a seed
    drive(0, 0, 1, 1);
    tick();
    for (int v = 0; v <= 7; v++) beat(W'(v));
    beat(20); beat(40);
    check("unlock_still_locked", locked, 1);
    beat(60);
    check("unlock_locked", locked, 0);
    check("unlock_err", error_count, 3);
    check("unlock_loss", lock_loss_count, 1);
    check("unlock_word", word_count, 6);
    for (int v = 100; v <= 103; v++) beat(W'(v));
    check("relock_early", locked, 0);
    beat(104);
    check("relock_locked", locked, 1);

    // Clear together with an accepted mismatching beat
    drive(1, 77, 1, 1);
    tick();
    check("clr_locked", locked, 0);
    check("clr_pulse", error_pulse, 0);
    check("clr_word", word_count, 0);
    check("clr_err", error_count, 0);
    check("clr_loss", lock_loss_count, 0);
    drive(0, 0, 1, 0);
    tick();
    check("clr_pulse_after", error_pulse, 0);

    // Enable low for 10 cycles mid-stream
    for (int v = 0; v <= 9; v++) beat(W'(v));
    check("en_word_before", word_count, 5);
    drive(1, 10, 0, 0);
    tick();
    check("en_tready_low", s_axis.tready, 0);
    check("en_word_last", word_count, 6);
    for (int c = 0; c < 9; c++) begin
      drive(1, 11, 0, 0);
      tick();
    end
    check("en_word_frozen", word_count, 6);
    beat(11);
    check("en_word_reenable", word_count, 6);
    for (int v = 11; v <= 15; v++) beat(W'(v));
    check("en_word_resume", word_count, 11);
    check("en_err_resume", error_count, 0);
    check("en_locked_resume", locked, 1);

    // Asynchronous reset in the middle of a beat
    drive(1, 16, 1, 0);
    #2 rst_n = 0;
    #1;
    check("areset_locked", locked, 0);
    check("areset_pulse", error_pulse, 0);
    check("areset_word", word_count, 0);
    check("areset_err", error_count, 0);
    check("areset_loss", lock_loss_count, 0);
    check("areset_tready", s_axis.tready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 1, 0);
    tick();
    for (int v = 17; v <= 20; v++) beat(W'(v));
    check("areset_seed_not_locked", locked, 0);
    beat(21);
    check("areset_relock", locked, 1);

    // Randomised traffic against the model
    err_rate = 5;
    for (int c = 0; c < 4000; c++) begin
      logic [W-1:0] d;
      if (c % 250 == 0) err_rate = $urandom_range(1, 40);
      d = ($urandom_range(0, 99) < err_rate) ? W'($urandom_range(0, 300)) : m_exp;
      drive($urandom_range(0, 9) < 8,
            d,
            $urandom_range(0, 19) != 0,
            $urandom_range(0, 299) == 0);
      tick();
    end

    drive(0, 0, 1, 0);
    tick();
    check("pending_pulses", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
